// File: rtl/vedic_div16x8.sv
// Sequential restoring divider, 16-bit dividend by 8-bit divisor, one quotient bit per clock.
// A start/busy/done handshake wraps it; the result holds on the outputs until the next done.
module vedic_div16x8 #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [DVD_W-1:0] r_dvd;
  logic [DVS_W:0]   r_acc;
  logic [DVS_W-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic [DVD_W-1:0] r_quot;
  logic [DVS_W-1:0] r_rem;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic [DVS_W:0]   w_shift;
  logic [DVS_W+1:0] w_trial;
  logic             w_qbit;
  logic [DVS_W:0]   w_acc_next;
  logic [DVD_W-1:0] w_dvd_next;
  logic             w_unused_acc_msb;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_cnt == CNT_W'(DVD_W - 1));

  // The shifted partial remainder needs DVS_W+1 bits; the extra sign bit on the
  // trial subtraction tells us whether the divisor fits without losing a carry.
  assign w_shift    = {r_acc[DVS_W-1:0], r_dvd[DVD_W-1]};
  assign w_trial    = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_qbit     = ~w_trial[DVS_W+1];
  assign w_acc_next = w_qbit ? w_trial[DVS_W:0] : w_shift;
  assign w_dvd_next = {r_dvd[DVD_W-2:0], w_qbit};

  // A restored remainder is always below the divisor, so the top bit is never needed as input.
  assign w_unused_acc_msb = r_acc[DVS_W];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_next = (divisor == '0) ? S_DONE : S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_acc   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_RUN) begin
        r_acc <= w_acc_next;
        r_dvd <= w_dvd_next;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_quot <= w_dvd_next;
          r_rem  <= w_acc_next[DVS_W-1:0];
          r_dbz  <= 1'b0;
        end
      end else if (w_accept) begin
        r_dvd <= dividend;
        r_dvs <= divisor;
        r_acc <= '0;
        r_cnt <= '0;
        if (divisor == '0) begin
          r_quot <= '1;
          r_rem  <= dividend[DVS_W-1:0];
          r_dbz  <= 1'b1;
        end
      end
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule
